usb_frame_parser: RTL and testbench
===================================

USB_FRAME_PARSER -- requirements
Module: usb_frame_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, required value of header bits [15:8].
REQ-002 Parameter CNT_W, default 16, width of the good-frame counter.
REQ-003 Port clk, input, 1: system clock (50 MHz); all logic is in this single domain.
REQ-004 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port fifo_rdreq, output, 1: read request to the dual-clock RX FIFO read port.
REQ-006 Port fifo_q, input, 16: FIFO read data, valid exactly 1 cycle after fifo_rdreq (non-showahead).
REQ-007 Port fifo_rdempty, input, 1: FIFO read-side empty flag.
REQ-008 Port out_data, output, 16: payload word.
REQ-009 Port out_valid, output, 1: out_data valid.
REQ-010 Port out_ready, input, 1: consumer accepts; transfer occurs when out_valid & out_ready.
REQ-011 Port out_last, output, 1: qualifies the final payload word of a frame.
REQ-012 Port frame_done, output, 1: one-cycle pulse when the checksum word has been evaluated.
REQ-013 Port frame_ok, output, 1: checksum result, valid while frame_done is high.
REQ-014 Port ok_count, output, CNT_W: saturating count of good frames.
REQ-015 Port err_count, output, 8: saturating count of checksum failures.
REQ-016 Port sync_err_count, output, 8: saturating count of words discarded while hunting.

Function
REQ-017 Frame format: header {SYNC_BYTE, N[7:0]}, then N payload words (N = 0..255), then 1 checksum word.
REQ-018 Checksum: the 16-bit sum, modulo 2^16, of the header word and all N payload words.
REQ-019 States: HUNT, HDR_WAIT, PAYLOAD, CSUM; reset state is HUNT.
REQ-020 fifo_rdreq is asserted only when ~fifo_rdempty, no read is in flight, and the output register is empty or is being accepted in the same cycle.
REQ-021 At most one read is in flight; sustained throughput is 1 word per 2 clk cycles.
REQ-022 HUNT: a received word with [15:8] == SYNC_BYTE loads the length counter with N, seeds the checksum with the word, and moves to PAYLOAD (N > 0) or CSUM (N == 0).
REQ-023 HUNT: a received word with a non-matching sync byte is dropped, sync_err_count increments, and the state stays HUNT.
REQ-024 PAYLOAD: each received word is loaded into out_data with out_valid=1 and added to the checksum; the length counter decrements.
REQ-025 PAYLOAD: out_last=1 on the word that brings the length counter to 0, after which the state moves to CSUM.
REQ-026 out_data, out_valid and out_last hold stable while out_valid & ~out_ready.
REQ-027 CSUM: the received word is compared with the running sum; frame_done pulses for 1 cycle with frame_ok = match; the state returns to HUNT.
REQ-028 frame_done fires 1 cycle after the checksum word arrives on fifo_q, and may coincide with a pending out_last word still awaiting out_ready.
REQ-029 A match increments ok_count and a mismatch increments err_count; all counters saturate at all-ones and never wrap.
REQ-030 A FIFO going empty mid-frame stalls the parser in its current state indefinitely (no timeout).
REQ-031 Payload is not discarded on a bad checksum; the consumer uses frame_ok to drop the frame.

Reset
REQ-032 Asserting reset_n low, at any time including mid-frame, forces HUNT and sets all outputs and counters to 0.
REQ-033 Asserting reset_n low cancels any in-flight read; the data word returned for that read is ignored.
REQ-034 After reset_n deasserts, fifo_rdreq may assert no earlier than the 2nd rising clk edge.

Structure
REQ-035 Package usb_cmd_pkg holds the SYNC_BYTE default, the state encoding constants, and the header field positions.
REQ-036 A single sub-module, sat_counter (parameterised width, enable, async active-low reset), is instantiated 3 times.

Verification
REQ-037 FIFO {A503, 0001, 0002, 0003, A509}: out_data 0001, 0002, 0003 with out_last on 0003; frame_done=1, frame_ok=1; ok_count=1.
REQ-038 FIFO {A500, A500}: no out_valid; frame_done with frame_ok=1; ok_count=1.
REQ-039 FIFO {1234, FFFF, A501, 0007, 0000}: sync_err_count=2; out_data 0007 with out_last; frame_ok=0; err_count=1.
REQ-040 Frame A502, 0001, 0002, A505 with out_ready held 0 for 20 cycles: out_data stays 0001, only 1 further read is issued, and there is no data loss after release.
REQ-041 Reset asserted after payload word 2 of an N=4 frame: all outputs are 0 immediately; a following frame A501, 00FF, A600 parses OK.
REQ-042 With err_count forced to 255, 1 more bad frame is received: err_count stays 255.

Source files
------------

// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the USB RX frame parser: sync default, FSM encoding,
// header field positions and small header field extractors.
package usb_cmd_pkg;

  // Default value expected in the header sync byte.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Header word layout: {sync[15:8], length[7:0]}.
  localparam int HDR_SYNC_MSB = 15;
  localparam int HDR_SYNC_LSB = 8;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 0;

  // Parser FSM encoding. The value is also exported on the debug port.
  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,  // idle, issuing the read for a candidate header
    ST_HDR_WAIT = 2'd1,  // header read in flight, evaluate sync on arrival
    ST_PAYLOAD  = 2'd2,  // forwarding payload words to the output register
    ST_CSUM     = 2'd3   // waiting for and evaluating the checksum word
  } state_t;

  // Extract the sync byte of a header word.
  function automatic logic [7:0] hdr_sync(input logic [15:0] word);
    return word[HDR_SYNC_MSB:HDR_SYNC_LSB];
  endfunction

  // Extract the payload length of a header word.
  function automatic logic [7:0] hdr_len(input logic [15:0] word);
    return word[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_en and sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  // Count enabled events, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count <= '0;
    end else if (i_en && (o_count != MAX)) begin
      o_count <= o_count + ONE;
    end
  end

endmodule

// File: rtl/usb_frame_parser.sv
// Parses {sync,len} / payload / checksum frames out of a non-showahead RX FIFO
// and forwards payload words through a single output register.
//
// Output handshake: out_data/out_last are qualified by out_valid; a word moves
// when out_valid & out_ready are both high at a rising clk edge, and while
// out_valid & ~out_ready the register contents are held unchanged.
module usb_frame_parser
  import usb_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  // RX FIFO read port (data returns one cycle after the request)
  output logic             fifo_rdreq,
  input  logic [15:0]      fifo_q,
  input  logic             fifo_rdempty,
  // Payload stream
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  // Frame result and statistics
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CNT_W-1:0] ok_count,
  output logic [7:0]       err_count,
  output logic [7:0]       sync_err_count,
  // Debug view of the parser FSM
  output logic [1:0]       o_dbg_state
);

  state_t      r_state;
  state_t      w_next_state;

  // Two-stage release qualifier: reads stay blocked for two edges after reset.
  logic [1:0]  r_rst_sync;
  // High in the cycle the requested word is present on fifo_q.
  logic        r_inflight;

  logic [7:0]  r_len;
  logic [15:0] r_sum;
  logic [15:0] r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_frame_done;
  logic        r_frame_ok;

  logic        w_rx;
  logic        w_out_free;
  logic        w_rd_en;
  logic        w_sync_match;
  logic        w_csum_match;
  logic        w_hdr_rx;
  logic        w_pay_rx;
  logic        w_csum_rx;
  logic        w_ok_inc;
  logic        w_err_inc;
  logic        w_sync_inc;

  assign w_rx         = r_inflight;
  assign w_out_free   = ~r_out_valid | out_ready;
  assign w_sync_match = (hdr_sync(fifo_q) == SYNC_BYTE);
  assign w_csum_match = (fifo_q == r_sum);

  // A read is only launched when data exists, nothing is outstanding, and the
  // output register can absorb whatever comes back next cycle.
  assign w_rd_en = r_rst_sync[1] & ~fifo_rdempty & ~r_inflight & w_out_free;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-word event decode; state only moves when a word lands.
  always_comb begin
    w_next_state = r_state;
    w_hdr_rx     = 1'b0;
    w_pay_rx     = 1'b0;
    w_csum_rx    = 1'b0;
    w_sync_inc   = 1'b0;
    w_ok_inc     = 1'b0;
    w_err_inc    = 1'b0;
    fifo_rdreq   = w_rd_en;
    case (r_state)
      ST_HUNT: begin
        if (w_rd_en) begin
          w_next_state = ST_HDR_WAIT;
        end
      end
      ST_HDR_WAIT: begin
        if (w_rx) begin
          if (w_sync_match) begin
            w_hdr_rx = 1'b1;
            if (hdr_len(fifo_q) == 8'd0) begin
              w_next_state = ST_CSUM;
            end else begin
              w_next_state = ST_PAYLOAD;
            end
          end else begin
            // Not a header: drop it and keep hunting.
            w_sync_inc   = 1'b1;
            w_next_state = ST_HUNT;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_rx) begin
          w_pay_rx = 1'b1;
          if (r_len == 8'd1) begin
            w_next_state = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (w_rx) begin
          w_csum_rx    = 1'b1;
          w_ok_inc     = w_csum_match;
          w_err_inc    = ~w_csum_match;
          w_next_state = ST_HUNT;
        end
      end
      default: begin
        w_next_state = ST_HUNT;
      end
    endcase
  end

  // Reset release qualifier and single-outstanding-read tracker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
      r_inflight <= 1'b0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
      r_inflight <= w_rd_en;
    end
  end

  // Length counter and running checksum, seeded by the header word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len <= 8'd0;
      r_sum <= 16'd0;
    end else if (w_hdr_rx) begin
      r_len <= hdr_len(fifo_q);
      r_sum <= fifo_q;
    end else if (w_pay_rx) begin
      r_len <= r_len - 8'd1;
      r_sum <= r_sum + fifo_q;
    end
  end

  // Output register: loaded by payload words, cleared when the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= 16'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_pay_rx) begin
      r_out_data  <= fifo_q;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_len == 8'd1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // One-cycle frame result pulse; frame_ok is only ever high alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
    end else begin
      r_frame_done <= w_csum_rx;
      r_frame_ok   <= w_csum_rx & w_csum_match;
    end
  end

  sat_counter #(.W(CNT_W)) u_ok_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_en    (w_ok_inc),
    .o_count (ok_count)
  );

  sat_counter #(.W(8)) u_err_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_en    (w_err_inc),
    .o_count (err_count)
  );

  sat_counter #(.W(8)) u_sync_err_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_en    (w_sync_inc),
    .o_count (sync_err_count)
  );

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign frame_done  = r_frame_done;
  assign frame_ok    = r_frame_ok;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_usb_frame_parser.sv
// Directed bench for usb_frame_parser: behavioural non-showahead FIFO, output
// monitor with expected queues, and hand-computed frame scenarios.
module tb_usb_frame_parser;
  import usb_cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset_n;
  logic        fifo_rdreq;
  logic [15:0] fifo_q;
  logic        fifo_rdempty;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] ok_count;
  logic [7:0]  err_count;
  logic [7:0]  sync_err_count;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  usb_frame_parser #(.SYNC_BYTE(8'hA5), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fifo_rdreq     (fifo_rdreq),
    .fifo_q         (fifo_q),
    .fifo_rdempty   (fifo_rdempty),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .frame_done     (frame_done),
    .frame_ok       (frame_ok),
    .ok_count       (ok_count),
    .err_count      (err_count),
    .sync_err_count (sync_err_count),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- FIFO model ----------------
  logic [15:0] fifo_mem[$];
  int          rd_cnt;

  initial begin
    fifo_q       = 16'd0;
    fifo_rdempty = 1'b1;
  end

  // Non-showahead read: data appears on fifo_q after the requesting edge.
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      rd_cnt = rd_cnt + 1;
      if (fifo_mem.size() > 0) fifo_q <= fifo_mem.pop_front();
    end
  end

  always @(negedge clk) fifo_rdempty <= (fifo_mem.size() == 0);

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_fail;
  logic [16:0] exp_q[$];   // {last, data}
  logic        done_q[$];  // expected frame_ok per frame_done
  int          n_extra_out;
  int          n_extra_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) n_extra_out = n_extra_out + 1;
      else chk("out_word", {15'd0, out_last, out_data}, {15'd0, exp_q.pop_front()});
    end
    if (reset_n && frame_done) begin
      if (done_q.size() == 0) n_extra_done = n_extra_done + 1;
      else chk("frame_ok", {31'd0, frame_ok}, {31'd0, done_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_w(input logic [15:0] w);
    fifo_mem.push_back(w);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    fifo_mem.delete();
    exp_q.delete();
    done_q.delete();
    n_extra_out  = 0;
    n_extra_done = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (fifo_mem.size() == 0 && exp_q.size() == 0 && done_q.size() == 0 &&
          dbg_state == ST_HUNT && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
    chk({tag, "_extra_out"}, n_extra_out, 0);
    chk({tag, "_extra_done"}, n_extra_done, 0);
  endtask

  task automatic chk_counts(input string tag, input int ok_e, input int err_e, input int sync_e);
    chk({tag, "_ok_count"}, {16'd0, ok_count}, ok_e);
    chk({tag, "_err_count"}, {24'd0, err_count}, err_e);
    chk({tag, "_sync_err"}, {24'd0, sync_err_count}, sync_e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    n_checks = 0;
    n_fail   = 0;
    rd_cnt   = 0;
    reset_n  = 1'b0;
    out_ready = 1'b1;
    n_extra_out  = 0;
    n_extra_done = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, ST_HUNT);
    chk_counts("rst", 0, 0, 0);

    // Basic 3-word frame, plus read gating just after reset release
    do_reset();
    push_w(16'hA503); push_w(16'h0001); push_w(16'h0002); push_w(16'h0003); push_w(16'hA509);
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0002});
    exp_q.push_back({1'b1, 16'h0003});
    done_q.push_back(1'b1);
    @(negedge clk); #1;
    chk("rdreq_before_edge1", {31'd0, fifo_rdreq}, 32'd0);
    @(posedge clk); #1;
    chk("rdreq_after_edge1", {31'd0, fifo_rdreq}, 32'd0);
    @(posedge clk); #1;
    chk("rdreq_after_edge2", {31'd0, fifo_rdreq}, 32'd1);
    wait_drain("t1_drain", 100);
    chk_counts("t1", 1, 0, 0);

    // Zero-length frame
    do_reset();
    push_w(16'hA500); push_w(16'hA500);
    done_q.push_back(1'b1);
    wait_drain("t2_drain", 100);
    chk_counts("t2", 1, 0, 0);

    // Garbage before header, bad checksum (A501+0007=A508)
    do_reset();
    push_w(16'h1234); push_w(16'hFFFF); push_w(16'hA501); push_w(16'h0007); push_w(16'h0000);
    exp_q.push_back({1'b1, 16'h0007});
    done_q.push_back(1'b0);
    wait_drain("t3_drain", 100);
    chk_counts("t3", 0, 1, 2);

    // Consumer backpressure for 20 cycles
    do_reset();
    out_ready = 1'b0;
    rd_cnt = 0;
    push_w(16'hA502); push_w(16'h0001); push_w(16'h0002); push_w(16'hA505);
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b1, 16'h0002});
    done_q.push_back(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("t4_first_valid", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_stall_data", {16'd0, out_data}, 32'h0001);
      chk("t4_stall_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("t4_stall_reads", rd_cnt, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t4_drain", 100);
    chk_counts("t4", 1, 0, 0);

    // Reset in the middle of an N=4 frame after two payload words
    do_reset();
    push_w(16'hA504); push_w(16'h0011); push_w(16'h0022);
    exp_q.push_back({1'b0, 16'h0011});
    exp_q.push_back({1'b0, 16'h0022});
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) begin seen = 1'b1; break; end
    end
    chk("t5_two_words", {31'd0, seen}, 32'd1);
    chk("t5_stalled_state", {30'd0, dbg_state}, ST_PAYLOAD);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_state", {30'd0, dbg_state}, ST_HUNT);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_data", {16'd0, out_data}, 32'd0);
    chk("t5_rst_last", {31'd0, out_last}, 32'd0);
    do_reset();
    push_w(16'hA501); push_w(16'h00FF); push_w(16'hA600);
    exp_q.push_back({1'b1, 16'h00FF});
    done_q.push_back(1'b1);
    wait_drain("t5_drain", 100);
    chk_counts("t5", 1, 0, 0);

    // err_count saturation: 256 bad zero-length frames
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push_w(16'hA500); push_w(16'h0001);
      done_q.push_back(1'b0);
    end
    wait_drain("t6_drain", 3000);
    chk_counts("t6", 0, 255, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
